dab_gate_driver: RTL and testbench
==================================

Name: dab_gate_driver

Overview:
- Sits directly downstream of the DAB phase-shift pattern generator.
- Converts each three-level bridge voltage command (V1 for the primary bridge, V2 for the secondary bridge; -1/0/+1) into four gate signals per H-bridge (Sp[3:0], Ss[3:0]).
- Inserts dead-time on every leg transition, forces safe-off on disable or illegal code, and latches a fault flag.

Parameters:
- DEADTIME, 8, both switches of a leg stay off for this many clk cycles on every leg transition (legal 1..255; 160 ns at 50 MHz).
- DT_W, 8, dead-time counter width.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset; asynchronous, active-low
- en  in  1  gate enable; 0 forces all gates off
- V1  in  2  signed primary bridge level command (+1, 0, -1)
- V2  in  2  signed secondary bridge level command
- Sp  out  4  primary gates: [0] leg A high, [1] leg A low, [2] leg B high, [3] leg B low
- Ss  out  4  secondary gates, same bit mapping as Sp
- fault  out  1  latched illegal-code (or shoot-through) fault

Behaviour:
- Reset (rst=0, asynchronous):
  - Sp=0, Ss=0, fault=0.
  - All four legs in OFF.
  - Registered commands v1_q/v2_q = 0.
  - Zero-polarity memories zpos1/zpos2 = 0.
- Input stage: V1/V2 registered every clk into v1_q/v2_q.
- Zero-polarity memory (per bridge): v_q=+1 sets zpos=1; v_q=-1 clears it; v_q=0 holds.
- Leg targets (per bridge):
  - Leg A: v_q=+1 -> H; v_q=-1 -> L; v_q=0 -> H if zpos else L.
  - Leg B: v_q=+1 -> L; v_q=-1 -> H; v_q=0 -> H if zpos else L.
  - Result: each zero interval switches only one leg (+1->0 moves leg B high; -1->0 moves leg B low).
- Leg FSM (4 instances, identical): states OFF, DT, ON_H, ON_L. Outputs are decoded from the registered state.
  - OFF: high=0, low=0. If en=1 and fault=0 -> DT with cnt=0.
  - DT: high=0, low=0. cnt increments each cycle; at cnt==DEADTIME-1 go to ON_H or ON_L per the target sampled that cycle. A target change during DT does not restart the count.
  - ON_H: high=1, low=0. Target L -> DT (cnt=0).
  - ON_L: high=0, low=1. Target H -> DT (cnt=0).
  - From any state: en=0 or fault=1 -> OFF on the next edge (higher priority than all other transitions).
- Latency: V change sampled at edge k -> v_q at edge k -> conducting switch off after edge k+1 -> complementary switch on after edge k+1+DEADTIME.
- Fault:
  - v1_q or v2_q == 2'b10 (-2) sets fault at the next edge; all legs go OFF.
  - fault is cleared only by rst=0 or by en=0 for at least one cycle, and only if the code is legal in that cycle.
  - Illegal code present together with en=0: fault stays/sets.
- Invariant: high and low gates of one leg are never 1 in the same cycle, including through reset, en toggles and fault.
- Startup from OFF with V=0 and zpos=0: all legs go to ON_L after DEADTIME (both bridges freewheel low).

Optional Feature:
- SHOOT_THROUGH_CHECK_EN defined: an independent comparator on the registered Sp/Ss outputs.
  - If any leg has high&low=1, fault is set at the next edge and all legs are forced OFF.
  - Cleared exactly like the illegal-code fault.
- Not defined: the comparator is absent and fault reflects illegal codes only.

Test Plan:
- Reset/startup:
  - Stimulus: DEADTIME=4, rst low then high, en=1, V1=V2=0.
  - Required: Sp=Ss=0 during reset; Sp=Ss=4'b1010 starting 4 cycles after leaving OFF.
- Positive step:
  - Stimulus: V1 0->+1 sampled at edge 10.
  - Required: Sp[1] falls after edge 11; Sp[0] rises after edge 15; Sp=4'b1001; Ss unchanged.
- Zero after +1:
  - Stimulus: V1 +1->0.
  - Required: only leg B moves; Sp[3] off at +1 cycle, Sp[2] on DEADTIME later; final Sp=4'b0101.
  - Follow-up: V1 -1->0 gives final Sp=4'b1010.
- Mid-dead-time reversal:
  - Stimulus: V1 flips back within 2 cycles of a leg change.
  - Required: leg stays both-off for exactly DEADTIME cycles, then takes the latest target; no overlap cycle.
- Illegal code:
  - Stimulus: V2=2'b10 for 1 cycle.
  - Required: fault=1 two edges later; Sp=Ss=0 and held.
  - Clearing: en=0 for 1 cycle clears fault; after en=1, outputs restart through DT.
- With SHOOT_THROUGH_CHECK_EN:
  - Stimulus: bench forces leg A state to drive Sp[0]=Sp[1]=1.
  - Required: fault=1 next edge; all gates 0 the edge after.

Source files
------------

// File: rtl/dab_gate_driver.sv
// Dead-time gate driver for a dual-active-bridge: two three-level commands -> eight gates.
// Optional build macro SHOOT_THROUGH_CHECK_EN adds an output overlap comparator feeding the fault latch.
module dab_gate_driver #(
  parameter int unsigned DEADTIME = 8,
  parameter int unsigned DT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] V1,
  input  logic [1:0] V2,
  output logic [3:0] Sp,
  output logic [3:0] Ss,
  output logic       fault
);

  typedef enum logic [1:0] {StOff, StDt, StOnH, StOnL} leg_state_e;

  localparam logic [DT_W-1:0] DtLast      = DT_W'(DEADTIME - 1);
  localparam logic [1:0]      CodePos     = 2'b01;
  localparam logic [1:0]      CodeNeg     = 2'b11;
  localparam logic [1:0]      CodeIllegal = 2'b10;

  logic [1:0]      v1_q, v2_q;
  logic            zpos1_q, zpos1_d, zpos2_q, zpos2_d;
  logic            fault_q, fault_d;
  logic            illegal;
  logic            shoot_through;
  logic [3:0]      tgt_h;
  logic [3:0]      gate_h, gate_l;
  leg_state_e      state_q [4];
  leg_state_e      state_d [4];
  logic [DT_W-1:0] cnt_q   [4];
  logic [DT_W-1:0] cnt_d   [4];

  // +1 remembers high, -1 remembers low, anything else keeps the last polarity.
  function automatic logic zpos_next(input logic [1:0] v, input logic z);
    if (v == CodePos) return 1'b1;
    if (v == CodeNeg) return 1'b0;
    return z;
  endfunction

  // Zero (and the one-cycle illegal window) parks both legs on the remembered rail,
  // so each zero interval moves only leg B.
  function automatic logic leg_a_high(input logic [1:0] v, input logic z);
    if (v == CodePos) return 1'b1;
    if (v == CodeNeg) return 1'b0;
    return z;
  endfunction

  function automatic logic leg_b_high(input logic [1:0] v, input logic z);
    if (v == CodePos) return 1'b0;
    if (v == CodeNeg) return 1'b1;
    return z;
  endfunction

  always_comb begin
    zpos1_d  = zpos_next(v1_q, zpos1_q);
    zpos2_d  = zpos_next(v2_q, zpos2_q);
    tgt_h[0] = leg_a_high(v1_q, zpos1_q);
    tgt_h[1] = leg_b_high(v1_q, zpos1_q);
    tgt_h[2] = leg_a_high(v2_q, zpos2_q);
    tgt_h[3] = leg_b_high(v2_q, zpos2_q);
  end

  assign illegal = (v1_q == CodeIllegal) || (v2_q == CodeIllegal);

`ifdef SHOOT_THROUGH_CHECK_EN
  assign shoot_through = (Sp[0] & Sp[1]) | (Sp[2] & Sp[3]) | (Ss[0] & Ss[1]) | (Ss[2] & Ss[3]);
`else
  assign shoot_through = 1'b0;
`endif

  // Clearing needs en low in a cycle whose registered codes are legal.
  always_comb begin
    fault_d = fault_q;
    if (illegal || shoot_through) begin
      fault_d = 1'b1;
    end else if (!en) begin
      fault_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!en || fault_q) begin
        state_d[i] = StOff;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          StOff: begin
            state_d[i] = StDt;
            cnt_d[i]   = '0;
          end
          StDt: begin
            if (cnt_q[i] == DtLast) begin
              state_d[i] = tgt_h[i] ? StOnH : StOnL;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          StOnH: begin
            if (!tgt_h[i]) begin
              state_d[i] = StDt;
              cnt_d[i]   = '0;
            end
          end
          StOnL: begin
            if (tgt_h[i]) begin
              state_d[i] = StDt;
              cnt_d[i]   = '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= '0;
      v2_q    <= '0;
      zpos1_q <= 1'b0;
      zpos2_q <= 1'b0;
      fault_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
      end
    end else begin
      v1_q    <= V1;
      v2_q    <= V2;
      zpos1_q <= zpos1_d;
      zpos2_q <= zpos2_d;
      fault_q <= fault_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Gates decode straight from leg state so high and low can never coincide.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      gate_h[i] = (state_q[i] == StOnH);
      gate_l[i] = (state_q[i] == StOnL);
    end
  end

  always_comb begin
    Sp    = {gate_l[1], gate_h[1], gate_l[0], gate_h[0]};
    Ss    = {gate_l[3], gate_h[3], gate_l[2], gate_h[2]};
    fault = fault_q;
  end

endmodule

// File: tb/tb_dab_gate_driver.sv
// Bench for dab_gate_driver: directed scenarios plus randomized traffic against a timeline model.
module tb_dab_gate_driver;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] V1, V2;
  logic [3:0] Sp, Ss;
  logic       fault;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: each leg is off, waiting for a release cycle, or conducting H (1) / L (2).
  int         m_cond  [4];
  bit         m_live  [4];
  int         m_ready [4];
  logic [1:0] m_v1, m_v2;
  bit         m_z1, m_z2;
  bit         m_fault;

  dab_gate_driver #(
    .DEADTIME(DT),
    .DT_W    (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .V1   (V1),
    .V2   (V2),
    .Sp   (Sp),
    .Ss   (Ss),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int code_val(input logic [1:0] c);
    logic signed [1:0] s;
    s = c;
    return int'(s);
  endfunction

  function automatic bit leg_high(input int v, input bit z, input bit is_b);
    if (v == 0 || v == -2) return z;
    return is_b ? (v == -1) : (v == 1);
  endfunction

  function automatic logic [3:0] exp_gates(input int base);
    logic [3:0] g;
    g[0] = (m_cond[base] == 1);
    g[1] = (m_cond[base] == 2);
    g[2] = (m_cond[base+1] == 1);
    g[3] = (m_cond[base+1] == 2);
    return g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cond[i]  = 0;
      m_live[i]  = 1'b0;
      m_ready[i] = 0;
    end
    m_v1 = 2'b00; m_v2 = 2'b00;
    m_z1 = 1'b0;  m_z2 = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_edge();
    int v1, v2;
    bit tgt [4];
    bit fn;
    if (!rst) begin
      model_reset();
      return;
    end
    v1 = code_val(m_v1);
    v2 = code_val(m_v2);
    tgt[0] = leg_high(v1, m_z1, 1'b0);
    tgt[1] = leg_high(v1, m_z1, 1'b1);
    tgt[2] = leg_high(v2, m_z2, 1'b0);
    tgt[3] = leg_high(v2, m_z2, 1'b1);
    if (v1 == -2 || v2 == -2) fn = 1'b1;
    else if (!en)             fn = 1'b0;
    else                      fn = m_fault;
    for (int i = 0; i < 4; i++) begin
      int want;
      want = tgt[i] ? 1 : 2;
      if (!en || m_fault) begin
        m_live[i] = 1'b0;
        m_cond[i] = 0;
      end else if (!m_live[i]) begin
        m_live[i]  = 1'b1;
        m_cond[i]  = 0;
        m_ready[i] = cyc + DT;
      end else if (m_cond[i] == 0) begin
        if (cyc == m_ready[i]) m_cond[i] = want;
      end else if (m_cond[i] != want) begin
        m_cond[i]  = 0;
        m_ready[i] = cyc + DT;
      end
    end
    if (v1 == 1) m_z1 = 1'b1; else if (v1 == -1) m_z1 = 1'b0;
    if (v2 == 1) m_z2 = 1'b1; else if (v2 == -1) m_z2 = 1'b0;
    m_v1 = V1;
    m_v2 = V2;
    m_fault = fn;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; V1 = 2'b00; V2 = 2'b00;
    model_reset();
    #1;
    repeat (3) step();
    checks++; if (Sp !== 4'b0000) begin errors++; $display("FAIL reset_sp got %b want 0000", Sp); end
    checks++; if (Ss !== 4'b0000) begin errors++; $display("FAIL reset_ss got %b want 0000", Ss); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    rst = 1'b1;
  endtask

  task automatic test_startup();
    for (int i = 1; i <= DT + 1; i++) begin
      logic [3:0] want;
      step();
      want = (i <= DT) ? 4'b0000 : 4'b1010;
      checks++;
      if (Sp !== want || Ss !== want) begin
        errors++;
        $display("FAIL startup edge %0d got Sp=%b Ss=%b want %b", i, Sp, Ss, want);
      end
    end
  endtask

  task automatic test_pos_step();
    V1 = 2'b01;
    step();
    checks++; if (Sp !== 4'b1010) begin errors++; $display("FAIL pos_k got %b want 1010", Sp); end
    step();
    checks++; if (Sp !== 4'b1000) begin errors++; $display("FAIL pos_low_off got %b want 1000", Sp); end
    repeat (DT - 1) step();
    checks++; if (Sp !== 4'b1000) begin errors++; $display("FAIL pos_dt got %b want 1000", Sp); end
    step();
    checks++; if (Sp !== 4'b1001) begin errors++; $display("FAIL pos_final got %b want 1001", Sp); end
    checks++; if (Ss !== 4'b1010) begin errors++; $display("FAIL pos_ss got %b want 1010", Ss); end
  endtask

  task automatic test_zero_after_pos();
    V1 = 2'b00;
    step();
    checks++; if (Sp !== 4'b1001) begin errors++; $display("FAIL zp_k got %b want 1001", Sp); end
    step();
    checks++; if (Sp !== 4'b0001) begin errors++; $display("FAIL zp_b_off got %b want 0001", Sp); end
    repeat (DT - 1) step();
    checks++; if (Sp !== 4'b0001) begin errors++; $display("FAIL zp_dt got %b want 0001", Sp); end
    step();
    checks++; if (Sp !== 4'b0101) begin errors++; $display("FAIL zp_final got %b want 0101", Sp); end
    V1 = 2'b11;
    step(); step();
    checks++; if (Sp !== 4'b0100) begin errors++; $display("FAIL neg_a_off got %b want 0100", Sp); end
    repeat (DT) step();
    checks++; if (Sp !== 4'b0110) begin errors++; $display("FAIL neg_final got %b want 0110", Sp); end
    V1 = 2'b00;
    step(); step();
    checks++; if (Sp !== 4'b0010) begin errors++; $display("FAIL zn_b_off got %b want 0010", Sp); end
    repeat (DT) step();
    checks++; if (Sp !== 4'b1010) begin errors++; $display("FAIL zn_final got %b want 1010", Sp); end
  endtask

  task automatic test_mid_dt_reversal();
    V1 = 2'b01;
    repeat (DT + 2) step();
    checks++; if (Sp !== 4'b1001) begin errors++; $display("FAIL rev_setup got %b want 1001", Sp); end
    V1 = 2'b11;
    step();
    V1 = 2'b01;
    for (int j = 1; j <= DT; j++) begin
      step();
      checks++;
      if (Sp !== 4'b0000) begin errors++; $display("FAIL rev_dt cycle %0d got %b want 0000", j, Sp); end
    end
    step();
    checks++; if (Sp !== 4'b1001) begin errors++; $display("FAIL rev_final got %b want 1001", Sp); end
  endtask

  task automatic test_illegal_code();
    V2 = 2'b10;
    step();
    V2 = 2'b00;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ill_early got %b want 0", fault); end
    step();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ill_set got %b want 1", fault); end
    step();
    checks++;
    if (Sp !== 4'b0000 || Ss !== 4'b0000) begin
      errors++; $display("FAIL ill_off got Sp=%b Ss=%b want 0000", Sp, Ss);
    end
    repeat (3) step();
    checks++;
    if (Sp !== 4'b0000 || Ss !== 4'b0000 || fault !== 1'b1) begin
      errors++; $display("FAIL ill_hold got Sp=%b Ss=%b fault=%b want 0000 0000 1", Sp, Ss, fault);
    end
    en = 1'b0;
    step();
    en = 1'b1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ill_clear got %b want 0", fault); end
    repeat (DT) step();
    checks++; if (Sp !== 4'b0000) begin errors++; $display("FAIL ill_restart_dt got %b want 0000", Sp); end
    step();
    checks++;
    if (Sp !== 4'b1001 || Ss !== 4'b1010) begin
      errors++; $display("FAIL ill_restart got Sp=%b Ss=%b want 1001 1010", Sp, Ss);
    end
    en = 1'b0; V2 = 2'b10;
    step();
    V2 = 2'b00;
    step();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ill_en_low got %b want 1", fault); end
    step();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ill_en_low_clr got %b want 0", fault); end
    en = 1'b1;
  endtask

  task automatic test_random();
    int hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (hold == 0) begin
        int r1, r2;
        r1 = $urandom_range(0, 47);
        r2 = $urandom_range(0, 47);
        V1 = (r1 == 0) ? 2'b10 : ((r1 % 3 == 0) ? 2'b00 : ((r1 % 3 == 1) ? 2'b01 : 2'b11));
        V2 = (r2 == 0) ? 2'b10 : ((r2 % 3 == 0) ? 2'b00 : ((r2 % 3 == 1) ? 2'b01 : 2'b11));
        hold = $urandom_range(1, 9);
      end
      hold--;
      en = ($urandom_range(0, 59) != 0);
      step();
      checks++;
      if (Sp !== exp_gates(0) || Ss !== exp_gates(2) || fault !== m_fault) begin
        errors++;
        $display("FAIL random cyc %0d got Sp=%b Ss=%b fault=%b want Sp=%b Ss=%b fault=%b",
                 cyc, Sp, Ss, fault, exp_gates(0), exp_gates(2), m_fault);
      end
      checks++;
      if ((Sp[0] & Sp[1]) | (Sp[2] & Sp[3]) | (Ss[0] & Ss[1]) | (Ss[2] & Ss[3])) begin
        errors++; $display("FAIL overlap cyc %0d got Sp=%b Ss=%b want no leg overlap", cyc, Sp, Ss);
      end
    end
  endtask

  task automatic test_async_reset();
    V1 = 2'b00; V2 = 2'b00; en = 1'b0;
    step();
    en = 1'b1;
    repeat (DT + 2) step();
    checks++;
    if (Sp !== exp_gates(0) || Sp === 4'b0000) begin
      errors++; $display("FAIL ar_pre got %b want %b (nonzero)", Sp, exp_gates(0));
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (Sp !== 4'b0000 || Ss !== 4'b0000 || fault !== 1'b0) begin
      errors++; $display("FAIL ar_async got Sp=%b Ss=%b fault=%b want 0000 0000 0", Sp, Ss, fault);
    end
    step();
    rst = 1'b1;
  endtask

`ifdef SHOOT_THROUGH_CHECK_EN
  task automatic test_shoot_through();
    repeat (DT + 2) step();
    force dut.Sp = 4'b1011;
    step();
    release dut.Sp;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL st_fault got %b want 1", fault); end
    step();
    checks++;
    if (Sp !== 4'b0000 || Ss !== 4'b0000) begin
      errors++; $display("FAIL st_off got Sp=%b Ss=%b want 0000", Sp, Ss);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_pos_step();
    test_zero_after_pos();
    test_mid_dt_reversal();
    test_illegal_code();
    test_random();
    test_async_reset();
`ifdef SHOOT_THROUGH_CHECK_EN
    test_shoot_through();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
